// File: rtl/pc_sequencer_pkg.sv
// Shared types and default widths for the PC run-control / branch sequencer.
// Optional statistics counters are enabled with `PC_SEQUENCER_STATS_EN.
package pc_seq_pkg;

    localparam int PC_W  = 10;
    localparam int LUT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/PC-side bundle of the sequencer: run control, branch request,
// LUT programming port and the PC control outputs.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int D = PC_W,
    parameter int L = LUT_W
);
    logic         start;
    logic         halt;
    logic         stall;
    logic         br_req;
    logic         br_cond;
    logic         br_rel;
    logic [L-1:0] lut_idx;
    logic [D-1:0] prog_ctr;
    logic         lut_wr_en;
    logic [L-1:0] lut_wr_idx;
    logic [D-1:0] lut_wr_data;
    logic         pc_rst;
    logic         reljump_en;
    logic         absjump_en;
    logic [D-1:0] target;
    logic         busy;
    logic         done;

    modport master (
        output start, halt, stall, br_req, br_cond, br_rel, lut_idx, prog_ctr,
               lut_wr_en, lut_wr_idx, lut_wr_data,
        input  pc_rst, reljump_en, absjump_en, target, busy, done
    );

    modport slave (
        input  start, halt, stall, br_req, br_cond, br_rel, lut_idx, prog_ctr,
               lut_wr_en, lut_wr_idx, lut_wr_data,
        output pc_rst, reljump_en, absjump_en, target, busy, done
    );
endinterface

// File: rtl/pc_sequencer_branch_lut.sv
// Branch-target register file: 2**L x D entries, cleared by reset,
// one registered write port and one combinational read port.
module branch_lut #(
    parameter int D = 10,
    parameter int L = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [L-1:0] wr_idx_i,
    input  logic [D-1:0] wr_data_i,
    input  logic [L-1:0] rd_idx_i,
    output logic [D-1:0] rd_data_o
);
    localparam int N = 2 ** L;

    logic [D-1:0] word_w [N];

    // Per-entry flops so the whole table clears on reset.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ent
            logic [D-1:0] entry_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_q <= '0;
                end else if (wr_en_i && (wr_idx_i == L'(gi))) begin
                    entry_q <= wr_data_i;
                end
            end
            assign word_w[gi] = entry_q;
        end
    endgenerate

    assign rd_data_o = word_w[rd_idx_i];

endmodule

// File: rtl/pc_sequencer.sv
// Run-control FSM and jump mux driving the program counter.
// Optional run/branch statistics are enabled with `PC_SEQUENCER_STATS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D = PC_W,
    parameter int L = LUT_W
) (
    input  logic            clk,
    input  logic            reset,
    pc_sequencer_if.slave   bus
`ifdef PC_SEQUENCER_STATS_EN
    ,
    output logic [31:0]     run_cycles,
    output logic [15:0]     taken_br
`endif
);
    seq_state_t   state_q, state_d;
    logic [D-1:0] lut_rd;
    logic         end_of_mem;
    logic         br_taken;
    logic         pc_rst_c;
    logic         rel_c;
    logic         abs_c;
    logic         busy_c;
    logic         done_c;
    logic [D-1:0] target_c;

    branch_lut #(.D(D), .L(L)) u_lut (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (bus.lut_wr_en),
        .wr_idx_i  (bus.lut_wr_idx),
        .wr_data_i (bus.lut_wr_data),
        .rd_idx_i  (bus.lut_idx),
        .rd_data_o (lut_rd)
    );

    assign end_of_mem = &bus.prog_ctr;
    assign br_taken   = bus.br_req & bus.br_cond;

    always_comb begin
        state_d  = state_q;
        pc_rst_c = 1'b0;
        rel_c    = 1'b0;
        abs_c    = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        target_c = '0;
        case (state_q)
            IDLE: begin
                pc_rst_c = 1'b1;
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (bus.halt) begin
                    rel_c   = 1'b1;
                    state_d = DONE;
                end else if (bus.stall) begin
                    rel_c = 1'b1;
                end else if (br_taken) begin
                    rel_c    = bus.br_rel;
                    abs_c    = ~bus.br_rel;
                    target_c = lut_rd;
                end else if (end_of_mem) begin
                    // Freeze at the last address instead of wrapping to 0.
                    rel_c   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                rel_c  = 1'b1;
                if (bus.start) begin
                    pc_rst_c = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign bus.pc_rst     = pc_rst_c;
    assign bus.reljump_en = rel_c;
    assign bus.absjump_en = abs_c;
    assign bus.target     = target_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;

`ifdef PC_SEQUENCER_STATS_EN
    logic [31:0] run_cycles_q;
    logic [15:0] taken_br_q;
    logic        start_acc;
    logic        count_br;

    assign start_acc = bus.start & (state_q != RUN);
    assign count_br  = (state_q == RUN) & ~bus.halt & ~bus.stall & br_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cycles_q <= '0;
            taken_br_q   <= '0;
        end else if (start_acc) begin
            run_cycles_q <= '0;
            taken_br_q   <= '0;
        end else begin
            if ((state_q == RUN) && !(&run_cycles_q)) run_cycles_q <= run_cycles_q + 32'd1;
            if (count_br && !(&taken_br_q))           taken_br_q   <= taken_br_q + 16'd1;
        end
    end

    assign run_cycles = run_cycles_q;
    assign taken_br   = taken_br_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; the bench itself plays the PC register.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int D = PC_W;
    localparam int L = LUT_W;

    typedef struct packed {
        logic         pc_rst;
        logic         rel;
        logic         abs;
        logic [D-1:0] target;
        logic         busy;
        logic         done;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.D(D), .L(L)) bus ();

`ifdef PC_SEQUENCER_STATS_EN
    logic [31:0] run_cycles;
    logic [15:0] taken_br;
    int unsigned m_runc;
    int unsigned m_tk;
`endif

    pc_sequencer #(.D(D), .L(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PC_SEQUENCER_STATS_EN
        ,
        .run_cycles (run_cycles),
        .taken_br   (taken_br)
`endif
    );

    exp_t       exp_q[$];
    seq_state_t m_state;
    logic [D-1:0] m_lut [2**L];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the bench's own state and the driven inputs.
    task automatic model_step(output exp_t e, output seq_state_t nxt, output logic tk, output logic acc);
        e   = '0;
        nxt = m_state;
        tk  = 1'b0;
        acc = 1'b0;
        if (m_state == IDLE) begin
            e.pc_rst = 1'b1;
            if (bus.start) begin nxt = RUN; acc = 1'b1; end
        end else if (m_state == DONE) begin
            e.done = 1'b1;
            e.rel  = 1'b1;
            if (bus.start) begin e.pc_rst = 1'b1; nxt = RUN; acc = 1'b1; end
        end else begin
            e.busy = 1'b1;
            if (bus.halt || bus.stall) begin
                e.rel = 1'b1;
                if (bus.halt) nxt = DONE;
            end else if (bus.br_req && bus.br_cond) begin
                tk       = 1'b1;
                e.target = m_lut[bus.lut_idx];
                if (bus.br_rel) e.rel = 1'b1;
                else            e.abs = 1'b1;
            end else if (bus.prog_ctr == {D{1'b1}}) begin
                e.rel = 1'b1;
                nxt   = DONE;
            end
        end
    endtask

    task automatic cycle(input string tag);
        exp_t e, got;
        seq_state_t nxt;
        logic tk, acc;
        logic [D-1:0] pc_n;
        model_step(e, nxt, tk, acc);
        exp_q.push_back(e);
        @(negedge clk);
        got = {bus.pc_rst, bus.reljump_en, bus.absjump_en, bus.target, bus.busy, bus.done};
        e = exp_q.pop_front();
        check_eq({tag, ".out"}, 32'(got), 32'(e));
        $display("[TB] %-10s pc=%03h rst=%0b rel=%0b abs=%0b tgt=%03h busy=%0b done=%0b",
                 tag, bus.prog_ctr, got.pc_rst, got.rel, got.abs, got.target, got.busy, got.done);
        @(posedge clk);
        if (got.pc_rst)   pc_n = '0;
        else if (got.abs) pc_n = got.target;
        else if (got.rel) pc_n = bus.prog_ctr + got.target;
        else              pc_n = bus.prog_ctr + 1'b1;
`ifdef PC_SEQUENCER_STATS_EN
        if (acc) begin
            m_runc = 0;
            m_tk   = 0;
        end else begin
            if (m_state == RUN && m_runc != 32'hFFFF_FFFF) m_runc++;
            if (tk && m_tk != 16'hFFFF) m_tk++;
        end
`endif
        m_state = nxt;
        if (bus.lut_wr_en) m_lut[bus.lut_wr_idx] = bus.lut_wr_data;
        #1;
        bus.prog_ctr = pc_n;
    endtask

    task automatic set_br(input logic rq, input logic cd, input logic rl, input logic [L-1:0] idx);
        bus.br_req  = rq;
        bus.br_cond = cd;
        bus.br_rel  = rl;
        bus.lut_idx = idx;
    endtask

    task automatic run_to(input logic [D-1:0] t, input int budget);
        int n = 0;
        while (bus.prog_ctr != t && n < budget) begin
            cycle("run");
            n++;
        end
        check_eq("reach_pc", 32'(bus.prog_ctr), 32'(t));
    endtask

    task automatic model_reset();
        m_state = IDLE;
        for (int i = 0; i < 2**L; i++) m_lut[i] = '0;
        exp_q.delete();
`ifdef PC_SEQUENCER_STATS_EN
        m_runc = 0;
        m_tk   = 0;
`endif
    endtask

    initial begin
        exp_t rst_exp, got;
        rst_exp        = '0;
        rst_exp.pc_rst = 1'b1;

        bus.start = 0; bus.halt = 0; bus.stall = 0;
        set_br(0, 0, 0, '0);
        bus.prog_ctr = '0;
        bus.lut_wr_en = 0; bus.lut_wr_idx = '0; bus.lut_wr_data = '0;
        model_reset();

        #12;
        got = {bus.pc_rst, bus.reljump_en, bus.absjump_en, bus.target, bus.busy, bus.done};
        check_eq("reset_out", 32'(got), 32'(rst_exp));
        @(posedge clk); #1 reset = 1'b1;

        repeat (5) cycle("idle");
        check_eq("idle_pc", 32'(bus.prog_ctr), 32'd0);

        bus.lut_wr_en = 1; bus.lut_wr_idx = 5'd3; bus.lut_wr_data = 10'h3FE;
        cycle("wr3");
        bus.lut_wr_idx = 5'd4; bus.lut_wr_data = 10'd40;
        cycle("wr4");
        bus.lut_wr_en = 0;

        bus.start = 1; cycle("start"); bus.start = 0;
        check_eq("start_pc", 32'(bus.prog_ctr), 32'd0);
        run_to(10'd5, 20);

        set_br(1, 1, 1, 5'd3); cycle("br_rel");
        check_eq("br_rel_pc", 32'(bus.prog_ctr), 32'd3);
        // start during RUN must not restart the PC
        bus.start = 1;
        set_br(1, 1, 0, 5'd4); cycle("br_abs");
        bus.start = 0;
        check_eq("br_abs_pc", 32'(bus.prog_ctr), 32'd40);

        // same-cycle write/read of idx5 returns the old (zero) entry
        bus.lut_wr_en = 1; bus.lut_wr_idx = 5'd5; bus.lut_wr_data = 10'd7;
        set_br(1, 1, 0, 5'd5); cycle("rdwr_same");
        bus.lut_wr_en = 0;
        check_eq("rdwr_pc", 32'(bus.prog_ctr), 32'd0);

        set_br(0, 0, 0, '0);
        run_to(10'd7, 20);
        set_br(1, 0, 1, 5'd3); cycle("br_nt");
        check_eq("br_nt_pc", 32'(bus.prog_ctr), 32'd8);
        bus.stall = 1; set_br(1, 1, 1, 5'd3); cycle("stall_br");
        bus.stall = 0;
        check_eq("stall_pc", 32'(bus.prog_ctr), 32'd8);
        set_br(1, 1, 0, 5'd5); cycle("br_new");
        check_eq("br_new_pc", 32'(bus.prog_ctr), 32'd7);

        set_br(0, 0, 0, '0);
        run_to(10'd12, 20);
        bus.halt = 1; cycle("halt"); bus.halt = 0;
        repeat (10) cycle("done");
        check_eq("halt_pc", 32'(bus.prog_ctr), 32'd12);
`ifdef PC_SEQUENCER_STATS_EN
        check_eq("run_cycles", run_cycles, 32'(m_runc));
        check_eq("taken_br", 32'(taken_br), 32'(m_tk));
`endif

        bus.start = 1; cycle("restart"); bus.start = 0;
        check_eq("restart_pc", 32'(bus.prog_ctr), 32'd0);
        run_to(10'h3FF, 1100);
        cycle("eom");
        repeat (3) cycle("done_eom");
        check_eq("eom_pc", 32'(bus.prog_ctr), 32'h3FF);

        bus.start = 1; cycle("start3"); bus.start = 0;
        repeat (3) cycle("run");
        check_eq("pre_rst_pc", 32'(bus.prog_ctr), 32'd3);

        // asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        got = {bus.pc_rst, bus.reljump_en, bus.absjump_en, bus.target, bus.busy, bus.done};
        check_eq("midrun_reset", 32'(got), 32'(rst_exp));
        model_reset();
        @(posedge clk); #1;
        bus.prog_ctr = '0;
        reset = 1'b1;

        bus.start = 1; cycle("start4"); bus.start = 0;
        set_br(1, 1, 1, 5'd3); cycle("lut_clr");
        check_eq("lut_clr_pc", 32'(bus.prog_ctr), 32'd0);
        set_br(1, 1, 0, 5'd4); cycle("lut_clr4");
        check_eq("lut_clr4_pc", 32'(bus.prog_ctr), 32'd0);
        set_br(0, 0, 0, '0);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Run-control and branch sequencer that drives the program counter's `reljump_en`, `absjump_en` and `target` inputs, plus a PC synchronous-reset strobe.
- Owns start/halt/done handshaking with the testbench/top level.
- Turns decoded branch requests into relative or absolute jumps through a software-loadable branch-target LUT.
- Sits between instruction decode and the PC.

Parameters:
- D, 10, PC/target width (matches PC).
- L, 5, LUT index width (2**L entries).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin program run; pulse or level.
- halt  in  1  decoded halt instruction at current PC.
- stall  in  1  hold PC this cycle.
- br_req  in  1  current instruction is a branch.
- br_cond  in  1  branch condition true.
- br_rel  in  1  1=relative offset, 0=absolute target.
- lut_idx  in  L  branch LUT read index.
- prog_ctr  in  D  current PC value.
- lut_wr_en  in  1  LUT write strobe.
- lut_wr_idx  in  L  LUT write index.
- lut_wr_data  in  D  LUT write data.
- pc_rst  out  1  synchronous reset to PC.
- reljump_en  out  1  to PC.
- absjump_en  out  1  to PC.
- target  out  D  to PC.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.

Behaviour:
- States: IDLE, RUN, DONE; the state register is the only FSM flop.
- Reset (reset=0, async):
  - state=IDLE, all LUT entries=0.
  - Outputs while in reset: pc_rst=1, reljump_en=0, absjump_en=0, target=0, busy=0, done=0.
- Outputs are combinational from state and current inputs. The PC registers them, so a jump takes effect at the next edge (1-cycle latency).
- IDLE:
  - pc_rst=1 every cycle; PC held at 0.
  - start=1 -> RUN.
- RUN, priority halt > stall > taken branch > increment:
  - halt=1: reljump_en=1, target=0 (PC holds the halt address); next state DONE.
  - stall=1: reljump_en=1, target=0; stay in RUN.
  - br_req & br_cond & br_rel: reljump_en=1, target=lut[lut_idx], interpreted as a two's-complement offset. Sum wraps modulo 2**D.
  - br_req & br_cond & !br_rel: absjump_en=1, target=lut[lut_idx].
  - br_req & !br_cond: no jump; PC increments.
  - End of memory: prog_ctr=={D{1}} with no halt, stall or taken branch -> reljump_en=1, target=0, next state DONE. The PC never wraps to 0 by increment.
  - start while in RUN is ignored.
- DONE:
  - done=1, reljump_en=1, target=0 (PC frozen).
  - start=1: pc_rst=1 this cycle, next state RUN; the first RUN cycle sees prog_ctr=0.
- reljump_en and absjump_en are never both 1.
- target=0 whenever neither jump enable is 1.
- LUT:
  - Write is registered at posedge and accepted in any state.
  - A read at the same index in the same cycle returns the old value.
- Reset asserted mid-RUN: immediate return to IDLE, outputs forced to reset values, LUT cleared.

Optional Feature:
- Macro `PC_SEQUENCER_STATS_EN`.
- When defined, adds two ports:
  - run_cycles out 32: counts cycles in RUN.
  - taken_br out 16: counts taken branches.
- Both counters:
  - Saturate at all-ones.
  - Clear on reset and on the start-accept cycle.
  - Hold their value in DONE.
- When not defined, neither the ports nor the counter logic exist; all other behaviour is identical.

Decomposition:
- Package pc_seq_pkg holds:
  - typedef enum logic[1:0] {IDLE, RUN, DONE} seq_state_t.
  - Localparams PC_W=10 and LUT_W=5 as defaults.
- One sub-module, branch_lut:
  - 2**L x D register file.
  - Async-clear on reset.
  - One registered write port, one combinational read port.
- The FSM and output mux stay in pc_sequencer.

Test Plan:
- Release reset, hold start=0 for 5 cycles -> pc_rst=1 every cycle, busy=0, done=0, jump enables 0.
- LUT: write idx3=10'h3FE (-2) and idx4=10'd40. Then start; at prog_ctr=5 apply br_req=1, br_cond=1, br_rel=1, lut_idx=3 -> reljump_en=1, target=10'h3FE, next PC=3. Then br_rel=0, lut_idx=4 -> absjump_en=1, target=40.
- br_req=1, br_cond=0 at prog_ctr=7 -> no enables, next PC=8. Apply stall+br together -> reljump_en=1, target=0, PC holds.
- halt at prog_ctr=12 -> next state DONE, PC stays 12 for 10 cycles, done=1. Then start -> pc_rst=1 one cycle, busy=1, prog_ctr=0.
- Run to prog_ctr=10'h3FF with no branches -> DONE entered, PC stays 3FF (no wrap).
- Assert reset low mid-RUN between clock edges -> outputs reach reset values before the next edge; LUT reads return 0.
